full_gray_decoder: RTL and testbench

//   Board-level top: 4-bit Gray code from switches is captured on a debounced press of `read`,

---
 rtl/gray_decoder_pkg.sv | 62 ++++++
 rtl/button_debouncer.sv | 46 ++++
 rtl/full_gray_decoder.sv | 105 ++++++++++
 tb/tb_full_gray_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gray_decoder_pkg.sv
// Shared constants for the Gray-code decoder board top: segment glyphs,
// scan digit indices and default timing.
package gray_decoder_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50_000;
  localparam int unsigned DEFAULT_REFRESH_CYCLES  = 50_000;

  typedef enum logic [1:0] {
    UNITS     = 2'd0,
    TENS      = 2'd1,
    HUNDREDS  = 2'd2,
    THOUSANDS = 2'd3
  } digitIdx_t;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] segCode(input logic [3:0] d);
    case (d)
      4'd0:    segCode = SEG_0;
      4'd1:    segCode = SEG_1;
      4'd2:    segCode = SEG_2;
      4'd3:    segCode = SEG_3;
      4'd4:    segCode = SEG_4;
      4'd5:    segCode = SEG_5;
      4'd6:    segCode = SEG_6;
      4'd7:    segCode = SEG_7;
      4'd8:    segCode = SEG_8;
      4'd9:    segCode = SEG_9;
      default: segCode = SEG_BLANK;
    endcase
  endfunction

  function automatic digitIdx_t nextDigit(input digitIdx_t d);
    case (d)
      UNITS:    nextDigit = TENS;
      TENS:     nextDigit = HUNDREDS;
      HUNDREDS: nextDigit = THOUSANDS;
      default:  nextDigit = UNITS;
    endcase
  endfunction

  function automatic logic [3:0] anodeFor(input digitIdx_t d);
    case (d)
      UNITS:    anodeFor = 4'b1110;
      TENS:     anodeFor = 4'b1101;
      HUNDREDS: anodeFor = 4'b1011;
      default:  anodeFor = 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises an asynchronous bouncy button, accepts a new level only after it
// has been stable for DEBOUNCE_CYCLES clocks, and flags the accepted rising edge.
module button_debouncer
  import gray_decoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic rawIn,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    syncQ;
  logic [CW-1:0] stableCnt;
  logic          level;
  logic          levelPrev;

  always_ff @(posedge clk) begin
    if (rst) begin
      syncQ     <= '0;
      stableCnt <= '0;
      level     <= 1'b0;
      levelPrev <= 1'b0;
    end else begin
      syncQ     <= {syncQ[0], rawIn};
      levelPrev <= level;
      // Counter only runs while the synchronised input disagrees with the accepted level.
      if (syncQ[1] != level) begin
        if (stableCnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level     <= syncQ[1];
          stableCnt <= '0;
        end else begin
          stableCnt <= stableCnt + 1'b1;
        end
      end else begin
        stableCnt <= '0;
      end
    end
  end

  assign rise = level & ~levelPrev;

endmodule

// File: rtl/full_gray_decoder.sv
// Board top: captures a Gray code on a debounced button press, shows the binary
// value on LEDs and its decimal value on a scanned 4-digit 7-segment display.
module full_gray_decoder
  import gray_decoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REFRESH_CYCLES  = DEFAULT_REFRESH_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read,
  input  logic [3:0] inSwitch,
  output logic       Digito_unidad,
  output logic       Digito_decena,
  output logic       Digito_centena,
  output logic       Digito_milesima,
  output logic       Digito_unidadNAN,
  output logic       Digito_decenaNAN,
  output logic       Digito_centenaNAN,
  output logic       Digito_milesimaNAN,
  output logic [6:0] cSeg7,
  output logic       LED8,
  output logic       LED4,
  output logic       LED2,
  output logic       LED1
);

  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [3:0]    swSync1;
  logic [3:0]    swSync2;
  logic [3:0]    grayQ;
  logic          pressRise;
  logic [3:0]    bin;
  logic          tens;
  logic [3:0]    units;
  logic [RW-1:0] refCnt;
  digitIdx_t     digitIdx;
  logic [3:0]    anodeQ;
  logic [3:0]    activeDigit;
  logic [3:0]    nanQ;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDebounce (
    .clk  (clk),
    .rst  (rst),
    .rawIn(read),
    .rise (pressRise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      swSync1 <= '0;
      swSync2 <= '0;
      grayQ   <= '0;
    end else begin
      swSync1 <= inSwitch;
      swSync2 <= swSync1;
      if (pressRise) grayQ <= swSync2;
    end
  end

  always_comb begin
    bin[3] = grayQ[3];
    bin[2] = bin[3] ^ grayQ[2];
    bin[1] = bin[2] ^ grayQ[1];
    bin[0] = bin[1] ^ grayQ[0];
    tens   = (bin >= 4'd10);
    units  = tens ? (bin - 4'd10) : bin;
  end

  // Anode register moves together with the index so glyph and anode switch in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      refCnt   <= '0;
      digitIdx <= UNITS;
      anodeQ   <= anodeFor(UNITS);
      nanQ     <= '1;
    end else begin
      nanQ <= '1;
      if (refCnt == RW'(REFRESH_CYCLES - 1)) begin
        refCnt   <= '0;
        digitIdx <= nextDigit(digitIdx);
        anodeQ   <= anodeFor(nextDigit(digitIdx));
      end else begin
        refCnt <= refCnt + 1'b1;
      end
    end
  end

  always_comb begin
    case (digitIdx)
      UNITS:   activeDigit = units;
      TENS:    activeDigit = {3'b000, tens};
      default: activeDigit = 4'd0;
    endcase
    cSeg7 = segCode(activeDigit);
  end

  assign {Digito_milesima, Digito_centena, Digito_decena, Digito_unidad} = anodeQ;
  assign {Digito_milesimaNAN, Digito_centenaNAN, Digito_decenaNAN, Digito_unidadNAN} = nanQ;
  assign {LED8, LED4, LED2, LED1} = bin;

endmodule

// File: tb/tb_full_gray_decoder.sv
// Scoreboard bench for full_gray_decoder with shortened debounce/refresh timing.
module tb_full_gray_decoder;

  localparam int unsigned DB = 16;
  localparam int unsigned RF = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read = 1'b0;
  logic [3:0] inSwitch = 4'b0000;
  logic       dU, dD, dC, dM, nU, nD, nC, nM;
  logic [6:0] cSeg7;
  logic       LED8, LED4, LED2, LED1;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] expQ[$];

  full_gray_decoder #(.DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF)) dut (
    .clk(clk), .rst(rst), .read(read), .inSwitch(inSwitch),
    .Digito_unidad(dU), .Digito_decena(dD), .Digito_centena(dC), .Digito_milesima(dM),
    .Digito_unidadNAN(nU), .Digito_decenaNAN(nD), .Digito_centenaNAN(nC),
    .Digito_milesimaNAN(nM),
    .cSeg7(cSeg7), .LED8(LED8), .LED4(LED4), .LED2(LED2), .LED1(LED1)
  );

  always #5 clk = ~clk;

  wire [3:0] leds   = {LED8, LED4, LED2, LED1};
  wire [3:0] anodes = {dM, dC, dD, dU};

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      9: return 7'b0010000; default: return 7'b1111111;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] sw);
    inSwitch = sw;
    expQ.push_back(g2b(sw));
    tick(4);
    read = 1'b1;
    tick(40);
    read = 1'b0;
    tick(40);
  endtask

  task automatic waitAnode(input int k, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (anodes === want) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    vectors++;
    if (leds !== 4'b0000) begin miscompares++; $display("FAIL reset_leds got=%b exp=0000", leds); end
    vectors++;
    if (anodes !== 4'b1110) begin miscompares++; $display("FAIL reset_anodes got=%b exp=1110", anodes); end
    vectors++;
    if (cSeg7 !== 7'b1000000) begin miscompares++; $display("FAIL reset_seg got=%b exp=1000000", cSeg7); end
    vectors++;
    if ({nM, nC, nD, nU} !== 4'b1111) begin
      miscompares++; $display("FAIL reset_nan got=%b exp=1111", {nM, nC, nD, nU});
    end
  endtask

  task automatic test_digits(input int t, input int u);
    bit ok;
    int want[4];
    want[0] = u; want[1] = t; want[2] = 0; want[3] = 0;
    for (int k = 0; k < 4; k++) begin
      waitAnode(k, ok);
      vectors++;
      if (!ok) begin
        miscompares++; $display("FAIL digit%0d_timeout anodes=%b", k, anodes);
      end else if (cSeg7 !== glyph(want[k])) begin
        miscompares++; $display("FAIL digit%0d_seg got=%b exp=%b", k, cSeg7, glyph(want[k]));
      end
    end
  endtask

  task automatic test_capture(input logic [3:0] sw, input string name);
    logic [3:0] e;
    press(sw);
    e = expQ.pop_front();
    vectors++;
    if (leds !== e) begin miscompares++; $display("FAIL %s got=%b exp=%b", name, leds, e); end
  endtask

  task automatic test_bounce;
    logic [3:0] hold;
    hold = leds;
    inSwitch = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      read = 1'b1; tick(3);
      read = 1'b0; tick(3);
    end
    inSwitch = 4'b1100;
    tick(40);
    vectors++;
    if (leds !== 4'b0011 || leds !== hold) begin
      miscompares++; $display("FAIL bounce_hold got=%b exp=0011", leds);
    end
  endtask

  task automatic test_scan;
    bit ok;
    logic prevU;
    logic [3:0] want;
    ok = 1'b0;
    prevU = dU;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (prevU === 1'b1 && dU === 1'b0) begin ok = 1'b1; break; end
      prevU = dU;
    end
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL scan_align_timeout anodes=%b", anodes);
    end else begin
      for (int i = 0; i < 64; i++) begin
        want = ~(4'b0001 << (i / 16));
        vectors++;
        if (anodes !== want) begin
          miscompares++; $display("FAIL scan_c%0d got=%b exp=%b", i, anodes, want);
        end
        tick(1);
      end
    end
  endtask

  task automatic test_reset_mid_press;
    logic [3:0] e;
    inSwitch = 4'b0110;
    tick(4);
    read = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    vectors++;
    if (leds !== 4'b0000) begin miscompares++; $display("FAIL rstpress_clear got=%b exp=0000", leds); end
    expQ.push_back(g2b(4'b0110));
    tick(8);
    vectors++;
    if (leds !== 4'b0000) begin miscompares++; $display("FAIL rstpress_early got=%b exp=0000", leds); end
    tick(32);
    e = expQ.pop_front();
    vectors++;
    if (leds !== e) begin miscompares++; $display("FAIL rstpress_capture got=%b exp=%b", leds, e); end
    read = 1'b0;
    tick(40);
  endtask

  initial begin
    tick(1);
    test_reset;
    test_capture(4'b0001, "cap_1");
    test_digits(0, 1);
    test_capture(4'b0011, "cap_2");
    test_capture(4'b0010, "cap_3");
    test_bounce;
    test_capture(4'b1000, "cap_15");
    test_digits(1, 5);
    test_scan;
    test_reset_mid_press;
    test_digits(0, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
